// File: rtl/obi_burst_loader.sv
`default_nettype none
// ============================================================================
// Module   : obi_burst_loader
// Purpose  : Buffers host write words in a FIFO and streams them into X-HEEP
//            as single-outstanding OBI writes; also serves OBI word readback.
// Revision : 1.0
// ============================================================================
module obi_burst_loader #(
   parameter int pDATA_WIDTH = 32,
   parameter int pADDR_WIDTH = 32,
   parameter int pFIFO_DEPTH = 8,
   parameter int pCNT_WIDTH  = 16
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            wr_valid,
   output logic                            wr_ready,
   input  logic [pDATA_WIDTH-1:0]          wr_data,
   input  logic                            addr_load,
   input  logic [pADDR_WIDTH-1:0]          addr_value,
   input  logic                            incr_en,
   input  logic                            rd_req,
   output logic                            rd_ready,
   input  logic [pADDR_WIDTH-1:0]          rd_addr,
   output logic                            rd_valid,
   output logic [pDATA_WIDTH-1:0]          rd_data,
   output logic [$clog2(pFIFO_DEPTH):0]    fifo_count,
   output logic                            busy,
   output logic [pCNT_WIDTH-1:0]           wr_done_count,
   output logic                            req,
   output logic                            we,
   output logic [pDATA_WIDTH/8-1:0]        be,
   output logic [pADDR_WIDTH-1:0]          addr,
   output logic [pDATA_WIDTH-1:0]          wdata,
   input  logic                            gnt,
   input  logic                            rvalid,
   input  logic [pDATA_WIDTH-1:0]          rdata
);

   localparam int c_ptr_w = $clog2(pFIFO_DEPTH);
   localparam int c_cnt_w = c_ptr_w + 1;
   localparam int c_be_w  = pDATA_WIDTH / 8;
   localparam logic [c_cnt_w-1:0]     c_depth  = c_cnt_w'(pFIFO_DEPTH);
   localparam logic [pADDR_WIDTH-1:0] c_stride = pADDR_WIDTH'(c_be_w);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR_REQ  = 3'd1,
      WR_RESP = 3'd2,
      RD_REQ  = 3'd3,
      RD_RESP = 3'd4
   } state_e;

   state_e                   state_q, state_d;
   logic [pDATA_WIDTH-1:0]   fifo_mem_q [pFIFO_DEPTH];
   logic [c_ptr_w-1:0]       wr_idx_q, wr_idx_d;
   logic [c_ptr_w-1:0]       rd_idx_q, rd_idx_d;
   logic [c_cnt_w-1:0]       count_q, count_d;
   logic [pADDR_WIDTH-1:0]   ptr_q, ptr_d;
   logic                     req_q, req_d;
   logic                     we_q, we_d;
   logic [c_be_w-1:0]        be_q, be_d;
   logic [pADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [pDATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic                     rd_valid_q, rd_valid_d;
   logic [pDATA_WIDTH-1:0]   rd_data_q, rd_data_d;
   logic                     busy_q, busy_d;
   logic [pCNT_WIDTH-1:0]    done_cnt_q, done_cnt_d;

   logic push;
   logic wr_grant;
   logic rd_accept;
   logic [pDATA_WIDTH-1:0] next_wdata;

   assign wr_ready  = (count_q < c_depth);
   assign rd_ready  = (state_q == IDLE) && (count_q == '0);
   assign push      = wr_valid & wr_ready;
   assign wr_grant  = req_q & we_q & gnt;
   assign rd_accept = rd_req & rd_ready;

   // A word pushed into an empty FIFO is forwarded straight onto wdata so the
   // request can be issued the very next cycle.
   assign next_wdata = (count_q == '0) ? wr_data : fifo_mem_q[rd_idx_q];

   always_comb begin
      wr_idx_d = push ? wr_idx_q + c_ptr_w'(1) : wr_idx_q;
      rd_idx_d = wr_grant ? rd_idx_q + c_ptr_w'(1) : rd_idx_q;
      count_d  = count_q;
      case ({push, wr_grant})
         2'b10:   count_d = count_q + c_cnt_w'(1);
         2'b01:   count_d = count_q - c_cnt_w'(1);
         default: count_d = count_q;
      endcase

      ptr_d = ptr_q;
      if (addr_load) begin
         ptr_d = addr_value;
      end else if (wr_grant && incr_en) begin
         ptr_d = ptr_q + c_stride;
      end
   end

   always_comb begin
      state_d    = state_q;
      req_d      = req_q;
      we_d       = we_q;
      be_d       = be_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      rd_valid_d = 1'b0;
      rd_data_d  = rd_data_q;
      done_cnt_d = done_cnt_q;

      case (state_q)
         IDLE: begin
            if (rd_accept) begin
               state_d = RD_REQ;
               req_d   = 1'b1;
               we_d    = 1'b0;
               be_d    = '1;
               addr_d  = rd_addr;
            end else if ((count_q != '0) || push) begin
               state_d = WR_REQ;
               req_d   = 1'b1;
               we_d    = 1'b1;
               be_d    = '1;
               addr_d  = ptr_d;
               wdata_d = next_wdata;
            end
         end
         WR_REQ: begin
            if (gnt) begin
               state_d = WR_RESP;
               req_d   = 1'b0;
               we_d    = 1'b0;
               be_d    = '0;
            end
         end
         WR_RESP: begin
            if (rvalid) begin
               state_d    = IDLE;
               done_cnt_d = done_cnt_q + pCNT_WIDTH'(1);
            end
         end
         RD_REQ: begin
            if (gnt) begin
               state_d = RD_RESP;
               req_d   = 1'b0;
               be_d    = '0;
            end
         end
         RD_RESP: begin
            if (rvalid) begin
               state_d    = IDLE;
               rd_data_d  = rdata;
               rd_valid_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE) || (count_d != '0);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         wr_idx_q   <= '0;
         rd_idx_q   <= '0;
         count_q    <= '0;
         ptr_q      <= '0;
         req_q      <= 1'b0;
         we_q       <= 1'b0;
         be_q       <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
         busy_q     <= 1'b0;
         done_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         wr_idx_q   <= wr_idx_d;
         rd_idx_q   <= rd_idx_d;
         count_q    <= count_d;
         ptr_q      <= ptr_d;
         req_q      <= req_d;
         we_q       <= we_d;
         be_q       <= be_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         rd_valid_q <= rd_valid_d;
         rd_data_q  <= rd_data_d;
         busy_q     <= busy_d;
         done_cnt_q <= done_cnt_d;
      end
   end

   // Storage needs no reset: occupancy is tracked by the indices and count.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem_q[wr_idx_q] <= wr_data;
      end
   end

   assign fifo_count    = count_q;
   assign busy          = busy_q;
   assign wr_done_count = done_cnt_q;
   assign req           = req_q;
   assign we            = we_q;
   assign be            = be_q;
   assign addr          = addr_q;
   assign wdata         = wdata_q;
   assign rd_valid      = rd_valid_q;
   assign rd_data       = rd_data_q;

endmodule
`default_nettype wire

// File: tb/tb_obi_burst_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_obi_burst_loader
// Purpose  : Directed self-checking bench for obi_burst_loader.
// Revision : 1.0
// ============================================================================
module tb_obi_burst_loader;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        wr_valid = 1'b0;
   logic        wr_ready;
   logic [31:0] wr_data = '0;
   logic        addr_load = 1'b0;
   logic [31:0] addr_value = '0;
   logic        incr_en = 1'b1;
   logic        rd_req = 1'b0;
   logic        rd_ready;
   logic [31:0] rd_addr = '0;
   logic        rd_valid;
   logic [31:0] rd_data;
   logic [3:0]  fifo_count;
   logic        busy;
   logic [15:0] wr_done_count;
   logic        req;
   logic        we;
   logic [3:0]  be;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        gnt = 1'b0;
   logic        rvalid = 1'b0;
   logic [31:0] rdata = '0;

   int n_pass = 0;
   int n_total = 0;

   obi_burst_loader #(
      .pDATA_WIDTH (32),
      .pADDR_WIDTH (32),
      .pFIFO_DEPTH (8),
      .pCNT_WIDTH  (16)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .wr_valid      (wr_valid),
      .wr_ready      (wr_ready),
      .wr_data       (wr_data),
      .addr_load     (addr_load),
      .addr_value    (addr_value),
      .incr_en       (incr_en),
      .rd_req        (rd_req),
      .rd_ready      (rd_ready),
      .rd_addr       (rd_addr),
      .rd_valid      (rd_valid),
      .rd_data       (rd_data),
      .fifo_count    (fifo_count),
      .busy          (busy),
      .wr_done_count (wr_done_count),
      .req           (req),
      .we            (we),
      .be            (be),
      .addr          (addr),
      .wdata         (wdata),
      .gnt           (gnt),
      .rvalid        (rvalid),
      .rdata         (rdata)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total = n_total + 1;
      assert (obs === exp) n_pass = n_pass + 1;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic push(input logic [31:0] d);
      wr_valid = 1'b1;
      wr_data  = d;
      @(negedge clk);
      wr_valid = 1'b0;
   endtask

   task automatic load(input logic [31:0] a);
      addr_load  = 1'b1;
      addr_value = a;
      @(negedge clk);
      addr_load  = 1'b0;
   endtask

   task automatic wait_req();
      for (int n = 0; n < 50 && req !== 1'b1; n++) @(negedge clk);
   endtask

   task automatic serve_write(input logic [31:0] ea, input logic [31:0] ed);
      wait_req();
      check("wr_req", req, 1);
      check("wr_we", we, 1);
      check("wr_be", be, 4'hF);
      check("wr_addr", addr, ea);
      check("wr_wdata", wdata, ed);
      gnt = 1'b1;
      @(negedge clk);
      gnt    = 1'b0;
      rvalid = 1'b1;
      rdata  = 32'hBAD0_0000;
      @(negedge clk);
      rvalid = 1'b0;
      rdata  = '0;
   endtask

   initial begin
      // Reset values
      repeat (3) @(negedge clk);
      check("rst_req", req, 0);
      check("rst_we", we, 0);
      check("rst_be", be, 0);
      check("rst_addr", addr, 0);
      check("rst_wdata", wdata, 0);
      check("rst_wr_ready", wr_ready, 1);
      check("rst_rd_ready", rd_ready, 1);
      check("rst_rd_valid", rd_valid, 0);
      check("rst_rd_data", rd_data, 0);
      check("rst_fifo_count", fifo_count, 0);
      check("rst_busy", busy, 0);
      check("rst_done", wr_done_count, 0);
      reset = 1'b0;

      // Incrementing burst of three words
      incr_en = 1'b1;
      load(32'h0000_0180);
      push(32'h11);
      check("lat_req", req, 1);
      check("lat_addr", addr, 32'h180);
      check("lat_wdata", wdata, 32'h11);
      push(32'h22);
      push(32'h33);
      check("t1_count", fifo_count, 3);
      check("t1_busy", busy, 1);
      serve_write(32'h180, 32'h11);
      serve_write(32'h184, 32'h22);
      serve_write(32'h188, 32'h33);
      check("t1_done", wr_done_count, 3);
      check("t1_busy_end", busy, 0);
      check("t1_count_end", fifo_count, 0);

      // Fill FIFO with grant withheld, then drain
      load(32'h0000_1000);
      for (int i = 0; i < 8; i++) push(32'hA0 + i);
      check("t2_count_full", fifo_count, 8);
      check("t2_wr_ready_full", wr_ready, 0);
      wr_valid = 1'b1;
      wr_data  = 32'hA8;
      @(negedge clk);
      check("t2_ninth_rejected", fifo_count, 8);
      check("t2_stall_req", req, 1);
      check("t2_stall_addr", addr, 32'h1000);
      check("t2_stall_wdata", wdata, 32'hA0);
      @(negedge clk);
      wr_valid = 1'b0;
      check("t2_stall_req2", req, 1);
      check("t2_stall_addr2", addr, 32'h1000);
      check("t2_stall_wdata2", wdata, 32'hA0);
      for (int i = 0; i < 8; i++) serve_write(32'h1000 + 4 * i, 32'hA0 + i);
      check("t2_count_end", fifo_count, 0);
      check("t2_busy_end", busy, 0);
      check("t2_done", wr_done_count, 11);

      // Fixed address
      incr_en = 1'b0;
      load(32'h2000_0000);
      for (int i = 0; i < 4; i++) push(32'h31 + i);
      for (int i = 0; i < 4; i++) serve_write(32'h2000_0000, 32'h31 + i);
      incr_en = 1'b1;

      // Address wrap
      load(32'hFFFF_FFFC);
      push(32'h41);
      push(32'h42);
      serve_write(32'hFFFF_FFFC, 32'h41);
      serve_write(32'h0000_0000, 32'h42);

      // Readback waits for queued writes
      load(32'h0000_3000);
      push(32'h51);
      push(32'h52);
      rd_req  = 1'b1;
      rd_addr = 32'h180;
      check("t5_rd_ready_busy", rd_ready, 0);
      serve_write(32'h3000, 32'h51);
      check("t5_rd_ready_mid", rd_ready, 0);
      serve_write(32'h3004, 32'h52);
      check("t5_rd_ready_free", rd_ready, 1);
      @(negedge clk);
      rd_req = 1'b0;
      check("t5_rd_req", req, 1);
      check("t5_rd_we", we, 0);
      check("t5_rd_be", be, 4'hF);
      check("t5_rd_addr", addr, 32'h180);
      gnt = 1'b1;
      @(negedge clk);
      gnt    = 1'b0;
      check("t5_rd_valid_early", rd_valid, 0);
      rvalid = 1'b1;
      rdata  = 32'hDEAD_BEEF;
      @(negedge clk);
      rvalid = 1'b0;
      rdata  = '0;
      check("t5_rd_valid", rd_valid, 1);
      check("t5_rd_data", rd_data, 32'hDEAD_BEEF);
      @(negedge clk);
      check("t5_rd_valid_pulse", rd_valid, 0);
      check("t5_rd_data_held", rd_data, 32'hDEAD_BEEF);
      check("t5_done", wr_done_count, 19);

      // Load coinciding with grant, then reset mid-request
      load(32'h0000_0100);
      push(32'h61);
      push(32'h62);
      wait_req();
      check("t6_addr0", addr, 32'h100);
      check("t6_wdata0", wdata, 32'h61);
      gnt        = 1'b1;
      addr_load  = 1'b1;
      addr_value = 32'h400;
      @(negedge clk);
      gnt       = 1'b0;
      addr_load = 1'b0;
      check("t6_addr_kept", addr, 32'h100);
      rvalid = 1'b1;
      @(negedge clk);
      rvalid = 1'b0;
      serve_write(32'h400, 32'h62);
      check("t6_done", wr_done_count, 21);
      push(32'h71);
      push(32'h72);
      check("t6_pre_rst_req", req, 1);
      check("t6_pre_rst_count", fifo_count, 2);
      reset = 1'b1;
      @(negedge clk);
      check("t6_rst_req", req, 0);
      check("t6_rst_count", fifo_count, 0);
      check("t6_rst_done", wr_done_count, 0);
      reset = 1'b0;
      @(negedge clk);
      check("t6_post_busy", busy, 0);
      check("t6_post_wr_ready", wr_ready, 1);
      check("t6_post_req", req, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
